jt10_adpcm_acc: RTL and testbench
=================================

Name: jt10_adpcm_acc

Overview:
- Channel accumulator/mixer directly downstream of the ADPCM-A gain stage.
- Receives one gained, panned stereo sample per channel slot, time-multiplexed across NCH channels.
- Sums one full round with wide headroom, saturates to 16 bits and presents one stereo output sample per round with a one-cycle strobe.
- Output feeds the final YM2610 mixer.

Parameters:
- NCH, 6, channels per round; counter wraps after NCH-1.
- ACCW, 19, accumulator width in bits; must be ≥ 16+ceil(log2(NCH)).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cen  input  1  clock enable; state advances only when high.
- div3  input  1  slot strobe; input valid when cen&div3.
- ch_first  input  1  marks the channel-0 slot; qualified by cen&div3.
- pcm_in_l  input  16  signed left sample from the gain stage.
- pcm_in_r  input  16  signed right sample from the gain stage.
- snd_l  output  16  signed saturated left mix.
- snd_r  output  16  signed saturated right mix.
- sample  output  1  one-clk pulse: snd_l/snd_r just updated.
- resync  output  1  one-clk pulse: round restarted early by ch_first.

Behaviour:
- Reset (async, rst_n low): cnt=0, acc_l=acc_r=0, snd_l=snd_r=0, sample=0, resync=0. Reset mid-round discards the partial sum; no output is produced.
- Strobe s = cen & div3. No state changes when s=0, except that sample and resync clear on the next clk edge regardless of cen.
- Slot index: idx = ch_first ? 0 : cnt.
- On s with idx==0: acc <= sign-extended input, which discards any prior partial sum.
- On s with idx!=0: acc <= acc + sign-extended input, at full ACCW width; no internal overflow for NCH full-scale inputs.
- Counter update on s: cnt <= (idx==NCH-1) ? 0 : idx+1.
- Round completion, on s with idx==NCH-1:
  - snd_l <= sat16(acc_l + pcm_in_l); snd_r likewise.
  - sample <= 1 for exactly one clk.
  - Latency is 1 clk from the last-slot strobe to valid output.
- sat16: sum > 32767 gives 32767; sum < -32768 gives -32768; otherwise sum[15:0].
- Early ch_first, on s with ch_first=1 while cnt!=0:
  - resync <= 1 for one clk.
  - Partial round dropped; snd_l, snd_r and sample unchanged.
  - Accumulation restarts with the current input as slot 0.
- ch_first with cnt==0: normal, no resync.
- ch_first when NCH==1: slot is both first and last; output produced, no resync.
- Outputs are held between rounds; snd_l/snd_r change only on completion.
- ch_first asserted when s=0 is ignored.
- Left and right paths are identical and fully independent.

Optional Feature:
- Macro JT10_ADPCM_ACC_CLIP_EN.
- When defined, adds ports:
  - clip_clr input 1.
  - clip_l output 1.
  - clip_r output 1.
- clip_l/clip_r are sticky flags, set on the clk edge where sat16 limits the respective channel at round completion.
- clip_clr=1 clears both flags on the next edge; a simultaneous set wins over clear.
- Flags reset to 0.
- When not defined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then 6 strobes with ch_first on slot 0, L=1000 and R=-500 each → one clk after slot 5: snd_l=6000, snd_r=-3000, sample high exactly 1 clk, resync low.
- 6 slots with L=20000 and R=-20000 → snd_l=32767, snd_r=-32768; with CLIP_EN: clip_l=clip_r=1 until clip_clr is pulsed.
- Slots 0..2 at L=100, then ch_first on the 4th strobe, then 6 slots at L=7 → resync pulse, no sample for the aborted round; next sample gives snd_l=42.
- div3 high with cen low for 20 cycles, interleaved with a valid round of L=1..6 → snd_l=21; the gated cycles have no effect.
- rst_n pulsed low after slot 3 of a round → all outputs 0 immediately; first full round after release gives the correct sum with no stale contribution.
- Alternating full rounds of +5 and -5 per slot → snd_l toggles 30 / -30; sample pulses once per round, exactly 6 strobes apart.

Source files
------------

// File: rtl/jt10_adpcm_acc.sv
// ADPCM-A channel accumulator: sums NCH gained stereo slots, saturates to 16 bits.
// Ports: clk, rst_n, cen, div3, ch_first, pcm_in_l/r in; snd_l/r, sample, resync out.
// Optional JT10_ADPCM_ACC_CLIP_EN adds clip_clr in, sticky clip_l/clip_r out.
module jt10_adpcm_acc #(
  parameter int NCH  = 6,
  parameter int ACCW = 19
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        div3,
  input  logic        ch_first,
  input  logic [15:0] pcm_in_l,
  input  logic [15:0] pcm_in_r,
`ifdef JT10_ADPCM_ACC_CLIP_EN
  input  logic        clip_clr,
  output logic        clip_l,
  output logic        clip_r,
`endif
  output logic [15:0] snd_l,
  output logic [15:0] snd_r,
  output logic        sample,
  output logic        resync
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  if (ACCW < 16 + $clog2(NCH)) begin : g_bad_accw
    $error("ACCW too narrow for NCH");
  end

  // Out of range when the bits above the 16-bit sign bit
  // disagree with it.
  function automatic logic ovf(input logic [ACCW-1:0] v);
    return !((&v[ACCW-1:15]) || !(|v[ACCW-1:15]));
  endfunction

  function automatic logic [15:0] sat16(input logic [ACCW-1:0] v);
    logic [15:0] r;
    if (ovf(v)) r = v[ACCW-1] ? 16'h8000 : 16'h7fff;
    else        r = v[15:0];
    return r;
  endfunction

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [ACCW-1:0] acc_l_q, acc_l_d;
  logic [ACCW-1:0] acc_r_q, acc_r_d;
  logic [15:0]     snd_l_q, snd_l_d;
  logic [15:0]     snd_r_q, snd_r_d;
  logic            sample_q, sample_d;
  logic            resync_q, resync_d;

  logic            s;
  logic [CW-1:0]   idx;
  logic            first;
  logic            last;
  logic [ACCW-1:0] ext_l;
  logic [ACCW-1:0] ext_r;
  logic [ACCW-1:0] sum_l;
  logic [ACCW-1:0] sum_r;

  assign s     = cen & div3;
  assign idx   = ch_first ? '0 : cnt_q;
  assign first = (idx == '0);
  assign last  = (idx == LAST);
  assign ext_l = {{(ACCW-16){pcm_in_l[15]}}, pcm_in_l};
  assign ext_r = {{(ACCW-16){pcm_in_r[15]}}, pcm_in_r};

  // Slot 0 ignores the old partial sum, so an early
  // ch_first discards it without a separate clear path.
  assign sum_l = (first ? '0 : acc_l_q) + ext_l;
  assign sum_r = (first ? '0 : acc_r_q) + ext_r;

  always_comb begin
    cnt_d    = cnt_q;
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    snd_l_d  = snd_l_q;
    snd_r_d  = snd_r_q;
    sample_d = 1'b0;
    resync_d = 1'b0;
    if (s) begin
      acc_l_d = sum_l;
      acc_r_d = sum_r;
      cnt_d   = last ? '0 : idx + 1'b1;
      if (last) begin
        snd_l_d  = sat16(sum_l);
        snd_r_d  = sat16(sum_r);
        sample_d = 1'b1;
      end
      if (ch_first && (cnt_q != '0)) resync_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      snd_l_q  <= '0;
      snd_r_q  <= '0;
      sample_q <= 1'b0;
      resync_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_l_q  <= acc_l_d;
      acc_r_q  <= acc_r_d;
      snd_l_q  <= snd_l_d;
      snd_r_q  <= snd_r_d;
      sample_q <= sample_d;
      resync_q <= resync_d;
    end
  end

  assign snd_l  = snd_l_q;
  assign snd_r  = snd_r_q;
  assign sample = sample_q;
  assign resync = resync_q;

`ifdef JT10_ADPCM_ACC_CLIP_EN
  logic clip_l_q, clip_l_d;
  logic clip_r_q, clip_r_d;
  logic done;

  assign done = s & last;

  // A set in the same cycle as clip_clr wins.
  always_comb begin
    clip_l_d = clip_clr ? 1'b0 : clip_l_q;
    clip_r_d = clip_clr ? 1'b0 : clip_r_q;
    if (done && ovf(sum_l)) clip_l_d = 1'b1;
    if (done && ovf(sum_r)) clip_r_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_l_q <= 1'b0;
      clip_r_q <= 1'b0;
    end else begin
      clip_l_q <= clip_l_d;
      clip_r_q <= clip_r_d;
    end
  end

  assign clip_l = clip_l_q;
  assign clip_r = clip_r_q;
`endif

endmodule

// File: tb/tb_jt10_adpcm_acc.sv
// Bench for jt10_adpcm_acc: scoreboard of expected stereo mixes.
// Scenario tasks drive slots; a monitor pops and compares on sample.
module tb_jt10_adpcm_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic        div3 = 1'b0;
  logic        ch_first = 1'b0;
  logic [15:0] pcm_in_l = '0;
  logic [15:0] pcm_in_r = '0;
  logic [15:0] snd_l;
  logic [15:0] snd_r;
  logic        sample;
  logic        resync;
`ifdef JT10_ADPCM_ACC_CLIP_EN
  logic        clip_clr = 1'b0;
  logic        clip_l;
  logic        clip_r;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_samp = 0;
  int n_resync = 0;
  int last_samp = -1;
  bit chk_gap = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  jt10_adpcm_acc dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .div3     (div3),
    .ch_first (ch_first),
    .pcm_in_l (pcm_in_l),
    .pcm_in_r (pcm_in_r),
`ifdef JT10_ADPCM_ACC_CLIP_EN
    .clip_clr (clip_clr),
    .clip_l   (clip_l),
    .clip_r   (clip_r),
`endif
    .snd_l    (snd_l),
    .snd_r    (snd_r),
    .sample   (sample),
    .resync   (resync)
  );

  always @(negedge clk) begin
    logic [31:0] e;
    cyc++;
    if (resync) n_resync++;
    if (sample) begin
      n_samp++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_sample got l=%0d r=%0d want none",
                 $signed(snd_l), $signed(snd_r));
      end else begin
        e = exp_q.pop_front();
        if ({snd_l, snd_r} !== e) begin
          bad++;
          $display("FAIL mix got l=%0d r=%0d want l=%0d r=%0d",
                   $signed(snd_l), $signed(snd_r),
                   $signed(e[31:16]), $signed(e[15:0]));
        end
      end
      if (chk_gap && last_samp >= 0) begin
        total++;
        if (cyc - last_samp !== 6) begin
          bad++;
          $display("FAIL sample_gap got %0d want 6", cyc - last_samp);
        end
      end
      last_samp = cyc;
    end
  end

  task automatic slot(input logic f, input logic [15:0] l,
                      input logic [15:0] r);
    cen = 1'b1;
    div3 = 1'b1;
    ch_first = f;
    pcm_in_l = l;
    pcm_in_r = r;
    @(posedge clk);
    #1;
    cen = 1'b0;
    div3 = 1'b0;
    ch_first = 1'b0;
  endtask

  task automatic round(input logic use_first, input logic [15:0] l,
                       input logic [15:0] r);
    for (int i = 0; i < 6; i++) slot(use_first && i == 0, l, r);
  endtask

  task automatic wait_idle(input string name);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL %s_pending got %0d want 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({snd_l, snd_r, sample, resync} !== 34'd0) begin
      bad++;
      $display("FAIL reset got l=%0d r=%0d s=%b y=%b want 0",
               snd_l, snd_r, sample, resync);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    exp_q.push_back({16'd6000, 16'(-3000)});
    round(1'b1, 16'd1000, 16'(-500));
    total++;
    if (sample !== 1'b1 || resync !== 1'b0 || snd_l !== 16'd6000) begin
      bad++;
      $display("FAIL basic_latency got s=%b y=%b l=%0d want 1 0 6000",
               sample, resync, $signed(snd_l));
    end
    @(posedge clk);
    #1;
    total++;
    if (sample !== 1'b0) begin
      bad++;
      $display("FAIL basic_pulse got %b want 0", sample);
    end
    wait_idle("basic");
  endtask

  task automatic test_sat;
    exp_q.push_back({16'h7fff, 16'h8000});
    round(1'b1, 16'd20000, 16'(-20000));
    wait_idle("sat");
`ifdef JT10_ADPCM_ACC_CLIP_EN
    total++;
    if ({clip_l, clip_r} !== 2'b11) begin
      bad++;
      $display("FAIL clip_set got %b%b want 11", clip_l, clip_r);
    end
    clip_clr = 1'b1;
    @(posedge clk);
    #1;
    clip_clr = 1'b0;
    total++;
    if ({clip_l, clip_r} !== 2'b00) begin
      bad++;
      $display("FAIL clip_clr got %b%b want 00", clip_l, clip_r);
    end
`endif
  endtask

  task automatic test_abort;
    int n0 = n_resync;
    exp_q.push_back({16'd42, 16'd0});
    slot(1'b1, 16'd100, 16'd0);
    slot(1'b0, 16'd100, 16'd0);
    slot(1'b0, 16'd100, 16'd0);
    slot(1'b1, 16'd7, 16'd0);
    total++;
    if (resync !== 1'b1 || sample !== 1'b0) begin
      bad++;
      $display("FAIL abort_resync got y=%b s=%b want 1 0", resync, sample);
    end
    for (int i = 0; i < 5; i++) slot(1'b0, 16'd7, 16'd0);
    wait_idle("abort");
    total++;
    if (n_resync - n0 !== 1) begin
      bad++;
      $display("FAIL abort_count got %0d want 1", n_resync - n0);
    end
  endtask

  task automatic gated(input int n);
    repeat (n) begin
      cen = 1'b0;
      div3 = 1'b1;
      ch_first = 1'($urandom_range(0, 1));
      pcm_in_l = 16'($urandom);
      pcm_in_r = 16'($urandom);
      @(posedge clk);
      #1;
    end
    div3 = 1'b0;
    ch_first = 1'b0;
  endtask

  task automatic test_gated;
    int n0 = n_resync;
    exp_q.push_back({16'd21, 16'd0});
    for (int i = 1; i <= 6; i++) begin
      slot(i == 1, 16'(i), 16'd0);
      if (i < 6) gated(4);
    end
    gated(6);
    wait_idle("gated");
    total++;
    if (snd_l !== 16'd21 || n_resync !== n0) begin
      bad++;
      $display("FAIL gated_hold got l=%0d y=%0d want 21 0",
               $signed(snd_l), n_resync - n0);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) slot(i == 0, 16'd1000, 16'd1000);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({snd_l, snd_r, sample, resync} !== 34'd0) begin
      bad++;
      $display("FAIL mid_reset got l=%0d r=%0d want 0",
               $signed(snd_l), $signed(snd_r));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back({16'd18, 16'(-18)});
    round(1'b0, 16'd3, 16'(-3));
    wait_idle("mid_reset");
  endtask

  task automatic test_back_to_back;
    int n0 = n_samp;
    chk_gap = 1;
    last_samp = -1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        exp_q.push_back({16'd30, 16'(-30)});
        round(1'b1, 16'd5, 16'(-5));
      end else begin
        exp_q.push_back({16'(-30), 16'd30});
        round(1'b1, 16'(-5), 16'd5);
      end
    end
    wait_idle("b2b");
    chk_gap = 0;
    total++;
    if (n_samp - n0 !== 4) begin
      bad++;
      $display("FAIL b2b_count got %0d want 4", n_samp - n0);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_sat;
    test_abort;
    test_gated;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got running want done");
    $fatal(1, "timeout");
  end

endmodule
